// File: rtl/pw_pkg.sv
// Shared types and default constants for the 800 ms stretched-pulse path
// (elongator on the transmit side, pulse_width_detector on the receive side).
package pw_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    WAIT_LOW = 2'd2
  } pw_state_t;

  // Nominal stretch is 800 ms at 100 MHz; the detector accepts +/-10 %.
  localparam int unsigned PULSE_WIDTH  = 80_000_000;
  localparam int unsigned PW_MIN_800MS = 72_000_000;
  localparam int unsigned PW_MAX_800MS = 88_000_000;
  localparam int unsigned PW_CNT_W     = 29;

endpackage

// File: rtl/pw_sync.sv
// Synchronizer for the asynchronous stretched-pulse line: SYNC_STAGES flops,
// one extra delay flop, and a rising-edge detect on the synchronized level.
module pw_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] valid_q;
  logic                   s_d;
  logic                   s_d_valid;

  // A marker bit travels beside the data so that s_d only counts as a real
  // previous sample once the chain has refilled after reset. A line that is
  // already high at reset release therefore never produces a rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      valid_q   <= '0;
      s_d       <= 1'b0;
      s_d_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      valid_q   <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      s_d       <= sync_q[SYNC_STAGES-1];
      s_d_valid <= valid_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d & s_d_valid;

endmodule

// File: rtl/pulse_width_detector.sv
// Recovers a single-cycle event from a stretched pulse, measuring its high time
// in clk cycles and classifying it as in-window, too short or too long.
module pulse_width_detector
  import pw_pkg::*;
#(
  parameter int unsigned MIN_WIDTH   = PW_MIN_800MS,
  parameter int unsigned MAX_WIDTH   = PW_MAX_800MS,
  parameter int unsigned CNT_W       = PW_CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic             detect,
  output logic             error_short,
  output logic             error_long,
  output logic [CNT_W-1:0] width,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);

  pw_state_t        state;
  logic [CNT_W-1:0] count;
  logic             s;
  logic             rise;

  pw_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .s        (s),
    .rise     (rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      width       <= '0;
      detect      <= 1'b0;
      error_short <= 1'b0;
      error_long  <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so each branch only raises the
      // one it owns; this keeps them single-cycle without extra clear logic.
      detect      <= 1'b0;
      error_short <= 1'b0;
      error_long  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            count <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (s) begin
            // Saturate at MAX_WIDTH: the counter never wraps.
            if (count == MAX_C) begin
              error_long <= 1'b1;
              width      <= MAX_C;
              state      <= WAIT_LOW;
            end else begin
              count <= count + 1'b1;
            end
          end else begin
            width <= count;
            if (count < MIN_C) error_short <= 1'b1;
            else               detect      <= 1'b1;
            state <= IDLE;
          end
        end
        WAIT_LOW: begin
          if (!s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_width_detector.sv
// Directed bench for pulse_width_detector with MIN_WIDTH=8, MAX_WIDTH=12,
// SYNC_STAGES=2; expected strobe kinds, widths and timings are hand-derived.
module tb_pulse_width_detector;

  localparam int unsigned CNT_W = 29;
  localparam int KD_DET   = 1;
  localparam int KD_SHORT = 2;
  localparam int KD_LONG  = 4;

  logic             clk;
  logic             reset;
  logic             pulse_in;
  logic             detect;
  logic             error_short;
  logic             error_long;
  logic [CNT_W-1:0] width;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // Per-run record of strobes (index of the sampling negedge, kind, width).
  int          nstr;
  int          busy_cnt;
  int          st_at   [2];
  logic [2:0]  st_kind [2];
  logic [31:0] st_w    [2];

  pulse_width_detector #(
    .MIN_WIDTH   (8),
    .MAX_WIDTH   (12),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .detect      (detect),
    .error_short (error_short),
    .error_long  (error_long),
    .width       (width),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    nstr     = 0;
    busy_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      st_at[k]   = -1;
      st_kind[k] = 3'b000;
      st_w[k]    = 32'hFFFF_FFFF;
    end
  endtask

  task automatic sample(input int i);
    if (detect || error_short || error_long) begin
      if (nstr < 2) begin
        st_at[nstr]   = i;
        st_kind[nstr] = {error_long, error_short, detect};
        st_w[nstr]    = 32'(width);
      end
      nstr++;
    end
    if (busy) busy_cnt++;
  endtask

  // Level of pulse_in at sampling posedge idx (1-based): first pulse h1 high,
  // gap low, optional second pulse h2 high, then low.
  function automatic logic lvl(input int idx, input int h1, input int gap, input int h2);
    return (idx >= 1 && idx <= h1) ||
           (h2 > 0 && idx > h1 + gap && idx <= h1 + gap + h2);
  endfunction

  // Must be entered just after a negedge; negedge i follows sampling posedge i.
  task automatic run_seq(input int h1, input int gap, input int h2, input int tail);
    int total;
    total = h1 + gap + h2 + tail;
    clear_rec();
    pulse_in = lvl(1, h1, gap, h2);
    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      sample(i);
      pulse_in = lvl(i + 1, h1, gap, h2);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_detect"},      32'(detect),      0);
    check({tag, "_error_short"}, 32'(error_short), 0);
    check({tag, "_error_long"},  32'(error_long),  0);
    check({tag, "_width"},       32'(width),       0);
    check({tag, "_busy"},        32'(busy),        0);
  endtask

  int t2_h    [4] = '{7, 8, 12, 13};
  int t2_kind [4] = '{KD_SHORT, KD_DET, KD_DET, KD_LONG};
  int t2_w    [4] = '{7, 8, 12, 12};
  int t2_at   [4] = '{10, 11, 15, 15};
  int t2_busy [4] = '{7, 8, 12, 13};

  initial begin
    reset    = 1'b0;
    pulse_in = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 1: 10-cycle pulse, strobe 3 edges after first low sample (posedge 11).
    run_seq(10, 0, 0, 6);
    check("t1_nstrobes", 32'(nstr), 1);
    check("t1_kind",     32'(st_kind[0]), KD_DET);
    check("t1_width",    st_w[0], 10);
    check("t1_latency",  32'(st_at[0]), 13);
    check("t1_busy",     32'(busy_cnt), 10);

    // 2: window boundaries.
    for (int j = 0; j < 4; j++) begin
      run_seq(t2_h[j], 0, 0, 6);
      check($sformatf("t2_h%0d_nstrobes", t2_h[j]), 32'(nstr), 1);
      check($sformatf("t2_h%0d_kind", t2_h[j]),     32'(st_kind[0]), 32'(t2_kind[j]));
      check($sformatf("t2_h%0d_width", t2_h[j]),    st_w[0], 32'(t2_w[j]));
      check($sformatf("t2_h%0d_at", t2_h[j]),       32'(st_at[0]), 32'(t2_at[j]));
      check($sformatf("t2_h%0d_busy", t2_h[j]),     32'(busy_cnt), 32'(t2_busy[j]));
    end

    // 3: very long pulse, one error_long on the 13th high cycle of s.
    run_seq(30, 0, 0, 6);
    check("t3_nstrobes", 32'(nstr), 1);
    check("t3_kind",     32'(st_kind[0]), KD_LONG);
    check("t3_width",    st_w[0], 12);
    check("t3_at",       32'(st_at[0]), 15);
    check("t3_busy",     32'(busy_cnt), 30);
    check("t3_width_held", 32'(width), 12);
    check("t3_idle",     32'(busy), 0);
    run_seq(10, 0, 0, 6);
    check("t3_next_kind",  32'(st_kind[0]), KD_DET);
    check("t3_next_width", st_w[0], 10);
    check("t3_next_nstr",  32'(nstr), 1);

    // 4: two 9-cycle pulses with a single low cycle between them.
    run_seq(9, 1, 9, 6);
    check("t4_nstrobes", 32'(nstr), 2);
    check("t4_kind0",    32'(st_kind[0]), KD_DET);
    check("t4_kind1",    32'(st_kind[1]), KD_DET);
    check("t4_width0",   st_w[0], 9);
    check("t4_width1",   st_w[1], 9);
    check("t4_at0",      32'(st_at[0]), 12);
    check("t4_at1",      32'(st_at[1]), 22);
    check("t4_busy",     32'(busy_cnt), 18);

    // 5: reset on the 6th high cycle of a 10-cycle pulse.
    pulse_in = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_busy_before", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("t5_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_rec();
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      sample(i);
      if (i == 3) pulse_in = 1'b0;
    end
    check("t5_nstrobes", 32'(nstr), 0);
    check("t5_busy",     32'(busy_cnt), 0);
    check("t5_width",    32'(width), 0);
    run_seq(10, 0, 0, 6);
    check("t5_next_nstr",  32'(nstr), 1);
    check("t5_next_kind",  32'(st_kind[0]), KD_DET);
    check("t5_next_width", st_w[0], 10);
    check("t5_next_at",    32'(st_at[0]), 13);

    // 6: input high before and through reset release, falls 20 cycles later.
    pulse_in = 1'b1;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clear_rec();
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      sample(i);
      if (i == 20) pulse_in = 1'b0;
    end
    check("t6_nstrobes", 32'(nstr), 0);
    check("t6_busy",     32'(busy_cnt), 0);
    check("t6_width",    32'(width), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
